// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Front-end conditioning between the board pins and the game core. Raw push
// buttons and slide switches are brought into the clock domain through
// two-flop synchronizers and then debounced. Buttons are debounced per bit and
// produce an active-high level plus one-cycle press/release pulses. Switches
// are debounced as a whole vector and produce a stable vector plus a one-cycle
// change pulse.
//
// Ports:
//   clock          - system clock, all logic on the rising edge
//   reset_signal   - synchronous reset, active-low
//   button_raw     - raw button pins, active-low (0 = pressed), asynchronous
//   sw_raw         - raw switch pins, asynchronous
//   button_level   - debounced button state, active-high (1 = held)
//   button_press   - one-cycle pulse per bit on a debounced 0->1 of button_level
//   button_release - one-cycle pulse per bit on a debounced 1->0 of button_level
//   sw_stable      - debounced switch vector
//   sw_changed     - one-cycle pulse when sw_stable is updated
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int BTN_DEBOUNCE_CYCLES = 500000,
  parameter int SW_DEBOUNCE_CYCLES  = 250000
) (
  input  logic       clock,
  input  logic       reset_signal,
  input  logic [2:0] button_raw,
  input  logic [7:0] sw_raw,
  output logic [2:0] button_level,
  output logic [2:0] button_press,
  output logic [2:0] button_release,
  output logic [7:0] sw_stable,
  output logic       sw_changed
);

  localparam int BTN_CW = $clog2(BTN_DEBOUNCE_CYCLES);
  localparam int SW_CW  = $clog2(SW_DEBOUNCE_CYCLES);

  localparam logic [BTN_CW-1:0] BTN_ZERO = BTN_CW'(0);
  localparam logic [BTN_CW-1:0] BTN_ONE  = BTN_CW'(1);
  localparam logic [BTN_CW-1:0] BTN_LAST = BTN_CW'(BTN_DEBOUNCE_CYCLES - 1);

  localparam logic [SW_CW-1:0] SW_ZERO = SW_CW'(0);
  localparam logic [SW_CW-1:0] SW_ONE  = SW_CW'(1);
  localparam logic [SW_CW-1:0] SW_LAST = SW_CW'(SW_DEBOUNCE_CYCLES - 1);

  logic [2:0]        btn_meta_r;
  logic [2:0]        btn_sync_r;
  logic [7:0]        sw_meta_r;
  logic [7:0]        sw_sync_r;
  logic [BTN_CW-1:0] btn_cnt_r [3];
  logic [7:0]        sw_cand_r;
  logic [SW_CW-1:0]  sw_cnt_r;

  // Two-flop synchronizers; buttons idle released (1), switches idle at 0.
  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      btn_meta_r <= 3'b111;
      btn_sync_r <= 3'b111;
      sw_meta_r  <= 8'h00;
      sw_sync_r  <= 8'h00;
    end else begin
      btn_meta_r <= button_raw;
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= sw_raw;
      sw_sync_r  <= sw_meta_r;
    end
  end

  // Per-button debounce: the counter only runs while the synchronized input
  // (inverted to active-high) disagrees with the debounced level, so any
  // bounce back restarts the full window.
  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      button_level   <= 3'b000;
      button_press   <= 3'b000;
      button_release <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        btn_cnt_r[i] <= BTN_ZERO;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        button_press[i]   <= 1'b0;
        button_release[i] <= 1'b0;
        if (~btn_sync_r[i] == button_level[i]) begin
          btn_cnt_r[i] <= BTN_ZERO;
        end else if (btn_cnt_r[i] == BTN_LAST) begin
          // Pulse is registered alongside the level so both appear together.
          button_level[i]   <= ~btn_sync_r[i];
          button_press[i]   <= ~btn_sync_r[i];
          button_release[i] <= btn_sync_r[i];
          btn_cnt_r[i]      <= BTN_ZERO;
        end else begin
          btn_cnt_r[i] <= btn_cnt_r[i] + BTN_ONE;
        end
      end
    end
  end

  // Switch-vector debounce: any bit change re-captures the candidate and
  // restarts the window; a candidate equal to the committed vector is idle.
  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      sw_cand_r  <= 8'h00;
      sw_cnt_r   <= SW_ZERO;
      sw_stable  <= 8'h00;
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= 1'b0;
      if (sw_sync_r != sw_cand_r) begin
        sw_cand_r <= sw_sync_r;
        sw_cnt_r  <= SW_ZERO;
      end else if (sw_cand_r == sw_stable) begin
        sw_cnt_r <= SW_ZERO;
      end else if (sw_cnt_r == SW_LAST) begin
        sw_stable  <= sw_cand_r;
        sw_changed <= 1'b1;
        sw_cnt_r   <= SW_ZERO;
      end else begin
        sw_cnt_r <= sw_cnt_r + SW_ONE;
      end
    end
  end

endmodule
